// File: rtl/serdes_var_pkg.sv
// Shared types for the variable-length word serialiser/deserialiser.
package serdes_var_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALIGN = 2'd2
    } state_e;

    // Default geometry: four 64-bit words.
    localparam int unsigned W_DEFAULT = 64;
    localparam int unsigned N_DEFAULT = 4;

endpackage : serdes_var_pkg

// File: rtl/serdes_var_if.sv
// Command, buffer and stream signals between a caller and serdes_var.
interface serdes_var_if #(
    parameter int unsigned W     = 64,
    parameter int unsigned N     = 4,
    parameter int unsigned LEN_W = $clog2(N + 1)
);
    logic               cmd_startDes;
    logic               cmd_startSer;
    logic [LEN_W-1:0]   cmd_numWords;
    logic               cmd_abort;
    logic               cmd_canReceive;
    logic               busy;
    logic [W*N-1:0]     buffer_read;
    logic [W*N-1:0]     buffer_write;
    logic [W-1:0]       des;
    logic               des_isReady;
    logic               des_canReceive;
    logic               des_isLast;
    logic [W-1:0]       ser;
    logic               ser_isReady;
    logic               ser_canReceive;
    logic               ser_isLast;

    // Caller side: issues commands, owns the buffer register and both streams' far ends.
    modport master (
        output cmd_startDes, cmd_startSer, cmd_numWords, cmd_abort,
        output buffer_read, des, des_isReady, ser_canReceive,
        input  cmd_canReceive, busy, buffer_write, des_canReceive, des_isLast,
        input  ser, ser_isReady, ser_isLast
    );

    // Block side.
    modport slave (
        input  cmd_startDes, cmd_startSer, cmd_numWords, cmd_abort,
        input  buffer_read, des, des_isReady, ser_canReceive,
        output cmd_canReceive, busy, buffer_write, des_canReceive, des_isLast,
        output ser, ser_isReady, ser_isLast
    );
endinterface : serdes_var_if

// File: rtl/serdes_var_rot.sv
// Combinational right-rotation of an N-word vector by sh words (sh in 0..N-1).
module serdes_var_rot #(
    parameter int unsigned W    = 64,
    parameter int unsigned N    = 4,
    parameter int unsigned SH_W = 2
) (
    input  logic [W*N-1:0] din,
    input  logic [SH_W-1:0] sh,
    output logic [W*N-1:0] rot_c
);
    localparam int unsigned BW = W * N;

    logic [2*BW-1:0] dbl;

    // Word i of the result is word (i+sh) mod N of the input.
    always_comb begin
        dbl   = {din, din};
        rot_c = BW'(dbl >> (W * 32'(sh)));
    end
endmodule : serdes_var_rot

// File: rtl/serdes_var.sv
// Variable-length word serdes: shifts an external W*N-bit buffer word by word out on ser
// and/or in from des, then re-aligns partial transfers so word 0 is the first word moved.
module serdes_var
    import serdes_var_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned LEN_W = $clog2(N + 1)
) (
    input logic         clk,
    input logic         rst,
    serdes_var_if.slave bus
);
    localparam int unsigned BW   = W * N;
    localparam int unsigned SH_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [LEN_W-1:0] N_L = LEN_W'(N);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic             is_ser_q, is_ser_d;
    logic             is_des_q, is_des_d;

    logic             accept;
    logic [LEN_W-1:0] k_new;
    logic [LEN_W-1:0] cnt_cur;
    logic [LEN_W-1:0] k_cur;
    logic             mode_ser;
    logic             mode_des;
    logic             run_now;
    logic             abort_run;
    logic             active;
    logic             step;
    logic [SH_W-1:0]  align_sh;
    logic [BW-1:0]    align_c;
    logic [BW-1:0]    des_shift_c;
    logic [BW-1:0]    rot1_c;

    // Single-word step paths are fixed wiring; a one-word buffer just takes des or holds.
    if (N > 1) begin : g_multi
        assign des_shift_c = {bus.des, bus.buffer_read[BW-1:W]};
        assign rot1_c      = {bus.buffer_read[W-1:0], bus.buffer_read[BW-1:W]};
    end else begin : g_single
        assign des_shift_c = bus.des;
        assign rot1_c      = bus.buffer_read;
    end

    // Alignment moves the first transferred word back to word 0.
    assign align_sh = SH_W'(N_L - k_q);

    serdes_var_rot #(
        .W    (W),
        .N    (N),
        .SH_W (SH_W)
    ) u_rot (
        .din   (bus.buffer_read),
        .sh    (align_sh),
        .rot_c (align_c)
    );

    // Effective transfer context; an accepted command runs in its own accept cycle.
    always_comb begin
        accept    = rst && (state_q == ST_IDLE) && (bus.cmd_startSer || bus.cmd_startDes);
        k_new     = (bus.cmd_numWords > N_L) ? N_L : bus.cmd_numWords;
        mode_ser  = accept ? bus.cmd_startSer : is_ser_q;
        mode_des  = accept ? bus.cmd_startDes : is_des_q;
        cnt_cur   = accept ? k_new : cnt_q;
        k_cur     = accept ? k_new : k_q;
        run_now   = rst && ((state_q == ST_RUN) || (accept && (k_new != '0)));
        abort_run = rst && (state_q == ST_RUN) && bus.cmd_abort;
        active    = run_now && !abort_run && (cnt_cur != '0);
        step      = active && (!mode_des || bus.des_isReady) && (!mode_ser || bus.ser_canReceive);
    end

    // Next-state, counter and mode capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        is_ser_d = is_ser_q;
        is_des_d = is_des_q;
        if (accept) begin
            is_ser_d = bus.cmd_startSer;
            is_des_d = bus.cmd_startDes;
            k_d      = k_new;
            cnt_d    = k_new;
        end
        case (state_q)
            ST_ALIGN: state_d = ST_IDLE;
            default:  ;
        endcase
        if (run_now) begin
            if (abort_run) begin
                state_d = ST_IDLE;
            end else if (step) begin
                cnt_d = cnt_cur - ONE;
                if (cnt_cur == ONE) begin
                    state_d = (k_cur == N_L) ? ST_IDLE : ST_ALIGN;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // Buffer update: align, step (des shift-in or ser rotate) or pass-through.
    always_comb begin
        bus.buffer_write = bus.buffer_read;
        if (rst && (state_q == ST_ALIGN)) begin
            bus.buffer_write = align_c;
        end else if (step) begin
            bus.buffer_write = mode_des ? des_shift_c : rot1_c;
        end
    end

    // Stream handshakes; in dual mode each side waits for the other.
    always_comb begin
        bus.cmd_canReceive = (state_q == ST_IDLE);
        bus.busy           = (state_q != ST_IDLE);
        bus.des_canReceive = active && mode_des && (!mode_ser || bus.ser_canReceive);
        bus.ser_isReady    = active && mode_ser && (!mode_des || bus.des_isReady);
        bus.des_isLast     = active && (cnt_cur == ONE);
        bus.ser_isLast     = bus.des_isLast;
        bus.ser            = bus.buffer_read[W-1:0];
    end

    // State and context registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            is_ser_q <= 1'b0;
            is_des_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            is_ser_q <= is_ser_d;
            is_des_q <= is_des_d;
        end
    end
endmodule : serdes_var

// File: tb/tb_serdes_var.sv
// Directed scoreboard bench for serdes_var with four 8-bit words.
module tb_serdes_var;
    localparam int unsigned W     = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned LEN_W = 3;

    typedef struct {
        logic [W-1:0] word;
        logic         last;
    } ser_exp_t;

    logic clk;
    logic rst;
    logic [W*N-1:0] mem_q;
    logic [W*N-1:0] load_val;
    logic load_en;

    int checks = 0;
    int errors = 0;

    ser_exp_t ser_q[$];
    logic     des_q[$];

    serdes_var_if #(.W(W), .N(N), .LEN_W(LEN_W)) bus ();

    serdes_var #(.W(W), .N(N), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller-owned buffer register.
    always @(posedge clk) mem_q <= load_en ? load_val : bus.buffer_write;
    assign bus.buffer_read = mem_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W*N-1:0] v);
        load_val = v;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
    endtask

    // Scoreboard: compare each completed stream handshake with the queued expectation.
    always @(negedge clk) begin
        if (bus.ser_isReady && bus.ser_canReceive) begin
            if (ser_q.size() == 0) begin
                chk("ser_extra", 32'(bus.ser), 32'hFFFF_FFFF);
            end else begin
                ser_exp_t e;
                e = ser_q.pop_front();
                chk("ser_word", 32'(bus.ser), 32'(e.word));
                chk("ser_last", 32'(bus.ser_isLast), 32'(e.last));
            end
        end
        if (bus.des_isReady && bus.des_canReceive) begin
            if (des_q.size() == 0) begin
                chk("des_extra", 32'(bus.des), 32'hFFFF_FFFF);
            end else begin
                logic l;
                l = des_q.pop_front();
                chk("des_last", 32'(bus.des_isLast), 32'(l));
            end
        end
    end

    initial begin
        rst = 1'b0;
        load_en = 1'b0;
        load_val = '0;
        bus.cmd_startDes = 1'b0;
        bus.cmd_startSer = 1'b0;
        bus.cmd_numWords = '0;
        bus.cmd_abort = 1'b0;
        bus.des = '0;
        bus.des_isReady = 1'b0;
        bus.ser_canReceive = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_des_canrx", 32'(bus.des_canReceive), 32'd0);
        chk("rst_ser_rdy", 32'(bus.ser_isReady), 32'd0);
        chk("rst_last", 32'({bus.des_isLast, bus.ser_isLast}), 32'd0);
        chk("rst_passthru", bus.buffer_write, bus.buffer_read);
        rst = 1'b1;
        load(32'h0);

        // Des-only, full length, back to back.
        des_q.push_back(1'b0); des_q.push_back(1'b0); des_q.push_back(1'b0); des_q.push_back(1'b1);
        bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd4; bus.des_isReady = 1'b1; bus.des = 8'h11;
        tick();
        bus.cmd_startDes = 1'b0; bus.des = 8'h22;
        tick();
        bus.des = 8'h33;
        tick();
        bus.des = 8'h44;
        #1 chk("t1_last", 32'(bus.des_isLast), 32'd1);
        tick();
        bus.des_isReady = 1'b0;
        #1 chk("t1_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        chk("t1_buf", mem_q, 32'h44332211);

        // Des-only k=2: two beats, one align cycle.
        des_q.push_back(1'b0); des_q.push_back(1'b1);
        bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd2; bus.des_isReady = 1'b1; bus.des = 8'hAA;
        tick();
        bus.cmd_startDes = 1'b0; bus.des = 8'hBB;
        tick();
        bus.des_isReady = 1'b0;
        #1 chk("t2_align_busy", 32'(bus.busy), 32'd1);
        chk("t2_align_canrx", 32'(bus.cmd_canReceive), 32'd0);
        tick();
        chk("t2_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("t2_buf", mem_q, 32'h4433BBAA);

        // Ser-only k=3 with sink stalling once.
        load(32'h0D0C0B0A);
        ser_q.push_back('{8'h0A, 1'b0}); ser_q.push_back('{8'h0B, 1'b0}); ser_q.push_back('{8'h0C, 1'b1});
        bus.cmd_startSer = 1'b1; bus.cmd_numWords = 3'd3; bus.ser_canReceive = 1'b1;
        tick();
        bus.cmd_startSer = 1'b0; bus.ser_canReceive = 1'b0;
        #1 chk("t3_hold_valid", 32'(bus.ser_isReady), 32'd1);
        tick();
        bus.ser_canReceive = 1'b1;
        tick();
        tick();
        bus.ser_canReceive = 1'b0;
        #1 chk("t3_align_busy", 32'(bus.busy), 32'd1);
        chk("t3_align_noready", 32'(bus.ser_isReady), 32'd0);
        tick();
        chk("t3_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("t3_buf", mem_q, 32'h0D0C0B0A);

        // Ser+des k=4 with a two-cycle des gap.
        load(32'h0D0C0B0A);
        ser_q.push_back('{8'h0A, 1'b0}); ser_q.push_back('{8'h0B, 1'b0});
        ser_q.push_back('{8'h0C, 1'b0}); ser_q.push_back('{8'h0D, 1'b1});
        des_q.push_back(1'b0); des_q.push_back(1'b0); des_q.push_back(1'b0); des_q.push_back(1'b1);
        bus.cmd_startSer = 1'b1; bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd4;
        bus.des_isReady = 1'b1; bus.des = 8'h01; bus.ser_canReceive = 1'b1;
        tick();
        bus.cmd_startSer = 1'b0; bus.cmd_startDes = 1'b0; bus.des = 8'h02;
        tick();
        bus.des_isReady = 1'b0;
        #1 chk("t4_gap1", 32'(bus.ser_isReady), 32'd0);
        tick();
        #1 chk("t4_gap2", 32'(bus.ser_isReady), 32'd0);
        tick();
        bus.des_isReady = 1'b1; bus.des = 8'h03;
        tick();
        bus.des = 8'h04;
        tick();
        bus.des_isReady = 1'b0; bus.ser_canReceive = 1'b0;
        #1 chk("t4_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("t4_buf", mem_q, 32'h04030201);

        // Abort after two of four des words: no align.
        des_q.push_back(1'b0); des_q.push_back(1'b0);
        bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd4; bus.des_isReady = 1'b1; bus.des = 8'h51;
        tick();
        bus.cmd_startDes = 1'b0; bus.des = 8'h52;
        tick();
        bus.cmd_abort = 1'b1; bus.des = 8'h53;
        #1 chk("t5_abort_wins", 32'(bus.des_canReceive), 32'd0);
        tick();
        bus.cmd_abort = 1'b0; bus.des_isReady = 1'b0;
        #1 chk("t5_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_buf", mem_q, 32'h52510403);

        // Zero-length command is a no-op.
        bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd0; bus.des_isReady = 1'b1; bus.des = 8'h5F;
        #1 chk("t5_nop_des", 32'(bus.des_canReceive), 32'd0);
        tick();
        bus.cmd_startDes = 1'b0; bus.des_isReady = 1'b0;
        #1 chk("t5_nop_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("t5_nop_buf", mem_q, 32'h52510403);

        // Oversized length clamps to N.
        des_q.push_back(1'b0); des_q.push_back(1'b0); des_q.push_back(1'b0); des_q.push_back(1'b1);
        bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd7; bus.des_isReady = 1'b1; bus.des = 8'h61;
        tick();
        bus.cmd_startDes = 1'b0; bus.des = 8'h62;
        tick();
        bus.des = 8'h63;
        tick();
        bus.des = 8'h64;
        tick();
        bus.des = 8'h65;
        #1 chk("t5_clamp_stop", 32'(bus.des_canReceive), 32'd0);
        tick();
        bus.des_isReady = 1'b0;
        #1 chk("t5_clamp_buf", mem_q, 32'h64636261);

        // Reset during RUN, then a fresh single-word command.
        des_q.push_back(1'b0);
        bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd4; bus.des_isReady = 1'b1; bus.des = 8'h71;
        tick();
        bus.cmd_startDes = 1'b0; rst = 1'b0; bus.des = 8'h72;
        #1 chk("t6_rst_gate", 32'(bus.des_canReceive), 32'd0);
        tick();
        rst = 1'b1; bus.des_isReady = 1'b0;
        #1 chk("t6_canrx", 32'(bus.cmd_canReceive), 32'd1);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_hs", 32'({bus.des_canReceive, bus.ser_isReady, bus.des_isLast}), 32'd0);
        chk("t6_passthru", bus.buffer_write, bus.buffer_read);
        des_q.push_back(1'b1);
        bus.cmd_startDes = 1'b1; bus.cmd_numWords = 3'd1; bus.des_isReady = 1'b1; bus.des = 8'h81;
        #1 chk("t6_new_last", 32'(bus.des_isLast), 32'd1);
        tick();
        bus.cmd_startDes = 1'b0; bus.des_isReady = 1'b0;
        #1 chk("t6_align", 32'(bus.busy), 32'd1);
        tick();
        chk("t6_done", 32'(bus.cmd_canReceive), 32'd1);
        chk("t6_buf", mem_q, 32'h71646381);

        // Every expected handshake must have happened.
        chk("ser_q_empty", 32'(ser_q.size()), 32'd0);
        chk("des_q_empty", 32'(des_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule : tb_serdes_var
